// File: rtl/eq_share_sched_pkg.sv
// Shared constants for the round-robin equality scheduler: FSM encoding and slice width.
package eq_sched_pkg;

    localparam int SLICE_W = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter width for S slice steps; a single-slice compare still needs one bit.
    function automatic int cnt_width(input int s);
        return (s > 1) ? $clog2(s) : 1;
    endfunction

endpackage

// File: rtl/eq_share_sched_if.sv
// Requester-side bus of the scheduler: request/operand inputs, grant and tagged result outputs.
interface eq_share_sched_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [N-1:0]   gnt;
    logic           busy;
    logic           done;
    logic           equal;
    logic [IW-1:0]  done_id;

    modport master (
        output req, a_in, b_in,
        input  gnt, busy, done, equal, done_id
    );

    modport slave (
        input  req, a_in, b_in,
        output gnt, busy, done, equal, done_id
    );
endinterface

// File: rtl/eq_share_sched_eq2_slice.sv
// Combinational 2-bit equality slice shared by all requesters; zero latency, no backpressure.
module eq2_slice (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic       z
);
    assign z = (x == y);
endmodule

// File: rtl/eq_share_sched.sv
// Round-robin scheduler serialising W-bit equality checks through one 2-bit slice, LSB first.
// Latency: done S cycles after gnt (earlier on first mismatch when EQ_SCHED_EARLY_EXIT_EN is defined).
module eq_share_sched
    import eq_sched_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    eq_share_sched_if.slave bus
);
    localparam int S  = W / SLICE_W;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = cnt_width(S);
    localparam logic [CW-1:0] CNT_LAST = CW'(S - 1);

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [W-1:0]  sha_q, sha_d;
    logic [W-1:0]  shb_q, shb_d;
    logic          acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          equal_q, equal_d;
    logic [IW-1:0] done_id_q, done_id_d;

    logic [IW-1:0] win;
    logic          slice_eq;
    logic          cmp_last;

    // First set request strictly after the last winner, wrapping; the last winner is checked last.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] p);
        logic [IW-1:0] w;
        logic          found;
        int            idx;
        w     = p;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(p) + k) % N;
            if (!found && r[idx]) begin
                w     = IW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign win = rr_pick(bus.req, ptr_q);

    eq2_slice u_slice (
        .x (sha_q[1:0]),
        .y (shb_q[1:0]),
        .z (slice_eq)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sha_d     = sha_q;
        shb_d     = shb_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        gnt_d     = '0;
        done_d    = 1'b0;
        equal_d   = 1'b0;
        done_id_d = '0;
        cmp_last  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    ptr_d   = win;
                    sha_d   = bus.a_in[int'(win)*W +: W];
                    shb_d   = bus.b_in[int'(win)*W +: W];
                    acc_d   = 1'b1;
                    cnt_d   = '0;
                    gnt_d   = N'(1) << win;
                    busy_d  = 1'b1;
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                acc_d = acc_q & slice_eq;
                sha_d = sha_q >> SLICE_W;
                shb_d = shb_q >> SLICE_W;
                cmp_last = (cnt_q == CNT_LAST);
`ifdef EQ_SCHED_EARLY_EXIT_EN
                cmp_last = cmp_last | ~slice_eq;
`endif
                if (cmp_last) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    equal_d   = acc_d;
                    done_id_d = ptr_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= IW'(N - 1);
            sha_q     <= '0;
            shb_q     <= '0;
            acc_q     <= 1'b0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            equal_q   <= 1'b0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sha_q     <= sha_d;
            shb_q     <= shb_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            equal_q   <= equal_d;
            done_id_q <= done_id_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.equal   = equal_q;
    assign bus.done_id = done_id_q;

endmodule

// File: tb/tb_eq_share_sched.sv
// Directed and randomized checks of eq_share_sched against a rule-level reference model.
module tb_eq_share_sched;
    localparam int N = 4;
    localparam int W = 8;
    localparam int S = W / 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   m_ptr = N - 1;

    logic [W-1:0] a_op [N];
    logic [W-1:0] b_op [N];

    eq_share_sched_if #(.N(N), .W(W)) bus ();

    eq_share_sched #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_ops();
        for (int i = 0; i < N; i++) begin
            bus.a_in[i*W +: W] = a_op[i];
            bus.b_in[i*W +: W] = b_op[i];
        end
    endtask

    // Round-robin rule: first pending index after the previous winner, wrapping.
    function automatic int rr_next(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef EQ_SCHED_EARLY_EXIT_EN
        for (int s = 0; s < S; s++) begin
            if (a[2*s +: 2] != b[2*s +: 2]) return s + 1;
        end
`endif
        return S;
    endfunction

    task automatic run_txn(input string tag, input logic [N-1:0] reqv, input bit drop);
        int  w;
        int  lat;
        bit  seen;
        w = rr_next(reqv, m_ptr);
        bus.req = reqv;
        seen = 1'b0;
        for (int n = 0; n < 4 && !seen; n++) begin
            tick();
            if (bus.gnt != '0) seen = 1'b1;
        end
        check({tag, ".gnt_seen"}, 32'(seen), 32'd1);
        check({tag, ".gnt"}, 32'(bus.gnt), 32'(1) << w);
        check({tag, ".busy_gnt"}, 32'(bus.busy), 32'd1);
        m_ptr = w;
        if (drop) bus.req[w] = 1'b0;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < S + 3) begin
            tick();
            lat++;
            if (lat == 1) check({tag, ".gnt_pulse"}, 32'(bus.gnt), 32'd0);
            if (bus.done) seen = 1'b1;
        end
        check({tag, ".done_seen"}, 32'(seen), 32'd1);
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat(a_op[w], b_op[w])));
        check({tag, ".equal"}, 32'(bus.equal), 32'(a_op[w] == b_op[w]));
        check({tag, ".done_id"}, 32'(bus.done_id), 32'(w));
        check({tag, ".busy_done"}, 32'(bus.busy), 32'd1);
        tick();
        check({tag, ".done_clr"}, 32'(bus.done), 32'd0);
        check({tag, ".busy_clr"}, 32'(bus.busy), 32'd0);
        check({tag, ".id_clr"}, 32'(bus.done_id), 32'd0);
    endtask

    initial begin
        int  sl;
        int  mode;
        bit  saw_done;
        logic [N-1:0] rq;

        for (int i = 0; i < N; i++) begin
            a_op[i] = '0;
            b_op[i] = '0;
        end
        load_ops();

        // Reset with all requests asserted: nothing may be granted.
        bus.req = 4'b1111;
        rst_n = 1'b0;
        tick();
        tick();
        check("rst.gnt", 32'(bus.gnt), 32'd0);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.equal", 32'(bus.equal), 32'd0);
        check("rst.done_id", 32'(bus.done_id), 32'd0);
        bus.req = '0;
        rst_n = 1'b1;
        tick();

        a_op[0] = 8'hA5; b_op[0] = 8'hA5;
        a_op[2] = 8'hA5; b_op[2] = 8'hA4;
        a_op[1] = 8'h25; b_op[1] = 8'hA5;
        load_ops();
        run_txn("eq_r0", 4'b0001, 1'b1);
        run_txn("lsb_diff_r2", 4'b0100, 1'b1);
        run_txn("msb_diff_r1", 4'b0010, 1'b1);

        // Held requests rotate fairly; dropping requester 2's line after its grant moves to 3.
        a_op[3] = 8'h3C; b_op[3] = 8'h3C;
        load_ops();
        m_ptr = N - 1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        run_txn("rr0", 4'b1111, 1'b0);
        run_txn("rr1", 4'b1111, 1'b0);
        run_txn("rr2", 4'b1111, 1'b0);
        run_txn("rr3", 4'b1001, 1'b0);
        run_txn("rr4", 4'b1111, 1'b0);
        bus.req = '0;

        // Reset two cycles into a compare: aborted, pointer returns to N-1.
        a_op[2] = 8'h77; b_op[2] = 8'h77;
        load_ops();
        bus.req = 4'b0100;
        tick();
        check("abort.gnt", 32'(bus.gnt), 32'b0100);
        bus.req = '0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_ptr = N - 1;
        check("abort.busy", 32'(bus.busy), 32'd0);
        check("abort.done", 32'(bus.done), 32'd0);
        saw_done = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (bus.done) saw_done = 1'b1;
        end
        check("abort.no_done", 32'(saw_done), 32'd0);
        run_txn("post_abort", 4'b0110, 1'b1);

        // Randomized traffic: equal, single-slice difference, or unrelated operands.
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < N; i++) begin
                a_op[i] = W'($urandom);
                mode = $urandom_range(0, 2);
                sl = $urandom_range(0, S - 1);
                if (mode == 0) b_op[i] = a_op[i];
                else if (mode == 1) b_op[i] = a_op[i] ^ (W'($urandom_range(1, 3)) << (2 * sl));
                else b_op[i] = W'($urandom);
            end
            load_ops();
            rq = N'($urandom_range(1, (1 << N) - 1));
            run_txn("rand", rq, 1'b1);
        end
        bus.req = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
